// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg: shared state type, channel count and cyclic channel search for demux_rr_sched
package demux_sched_pkg;
  localparam int NCH = 4;
  typedef enum logic {EMPTY, FULL} state_t;
  typedef struct packed {
    logic [1:0] target;
    logic       skipped;
  } pick_t;
  // ptr wins when enabled; otherwise the nearest enabled channel after it (lowest offset wins)
  function automatic pick_t next_enabled(input logic [1:0] ptr, input logic [NCH-1:0] en);
    pick_t p;
    p = '{target: ptr, skipped: 1'b0};
    for (int k = NCH - 1; k >= 1; k--)
      if (en[ptr + 2'(k)]) p = '{target: ptr + 2'(k), skipped: 1'b1};
    if (en[ptr]) p = '{target: ptr, skipped: 1'b0};
    return p;
  endfunction
endpackage

// File: rtl/demux_rr_sched_pick.sv
// rr_pick4: combinational cyclic first-enabled channel search
//   ptr     in  starting channel
//   en      in  per-channel enable
//   target  out chosen channel
//   skipped out ptr was disabled and a later channel was chosen
module rr_pick4 import demux_sched_pkg::*; (
  input  logic [1:0]     ptr,
  input  logic [NCH-1:0] en,
  output logic [1:0]     target,
  output logic           skipped
);
  pick_t p;
  assign p       = next_enabled(ptr, en);
  assign target  = p.target;
  assign skipped = p.skipped;
endmodule

// File: rtl/demux_rr_sched.sv
// demux_rr_sched: one-word buffered 1-to-4 demux scheduler rotating across enabled channels in bursts
//   clk, rst (async, active-high); in_valid/in_ready/in_data: producer stream; en: channel enables
//   out_valid/out_ready: per-channel handshake; out_data: held word; sel: demux select; busy: word held
//   stat_cnt: per-channel delivered-word counters, present only when DEMUX_SCHED_STATS_EN is defined
module demux_rr_sched import demux_sched_pkg::*; #(
  parameter int DW    = 8,
  parameter int BURST = 4,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  input  logic [NCH-1:0] en,
  output logic [NCH-1:0] out_valid,
  input  logic [NCH-1:0] out_ready,
  output logic [DW-1:0]  out_data,
  output logic [1:0]     sel,
  output logic           busy
`ifdef DEMUX_SCHED_STATS_EN
  , output logic [NCH*CNT_W-1:0] stat_cnt
`endif
);
  state_t        state;
  logic [DW-1:0] buf_r;
  logic [1:0]    ptr, ptr_n, target;
  logic [7:0]    bcnt, bcnt_n;
  logic          xfer, accept, skipped, last;
  assign xfer   = state == FULL && out_ready[sel];
  assign last   = bcnt == 8'(BURST - 1);
  // pointer follows the delivered word's channel, advancing after the burst's last word
  assign ptr_n  = !xfer ? ptr : last ? sel + 2'd1 : sel;
  assign bcnt_n = !xfer ? bcnt : last ? 8'd0 : bcnt + 8'd1;
  rr_pick4 u_pick (.ptr(ptr_n), .en(en), .target(target), .skipped(skipped));
  assign in_ready  = |en && (state == EMPTY || xfer);
  assign accept    = in_valid && in_ready;
  assign out_valid = state == FULL ? 4'b0001 << sel : 4'b0000;
  assign out_data  = buf_r;
  assign busy      = state == FULL;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= EMPTY;
      ptr   <= '0;
      bcnt  <= '0;
      sel   <= '0;
      buf_r <= '0;
    end else begin
      ptr  <= ptr_n;
      bcnt <= accept && skipped ? 8'd0 : bcnt_n;
      if (accept) begin
        buf_r <= in_data;
        sel   <= target;
        state <= FULL;
      end else if (xfer) state <= EMPTY;
    end
`ifdef DEMUX_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt [NCH];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int k = 0; k < NCH; k++) cnt[k] <= '0;
    else if (xfer) cnt[sel] <= cnt[sel] + CNT_W'(1);
  for (genvar i = 0; i < NCH; i++) begin : g_stat
    assign stat_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end
`endif
endmodule

// File: tb/tb_demux_rr_sched.sv
// tb_demux_rr_sched: directed bench for demux_rr_sched (BURST=4 and BURST=1 instances) against a behavioural model
module tb_demux_rr_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [3:0] en = 4'hF;
  logic [3:0] out_ready = 4'hF;
  logic       ir [2];
  logic [3:0] ov [2];
  logic [7:0] od [2];
  logic [1:0] sl [2];
  logic       bz [2];
`ifdef DEMUX_SCHED_STATS_EN
  logic [15:0] st [2];
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  demux_rr_sched #(.DW(8), .BURST(4), .CNT_W(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data), .en(en),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .sel(sl[0]), .busy(bz[0])
`ifdef DEMUX_SCHED_STATS_EN
    , .stat_cnt(st[0])
`endif
  );
  demux_rr_sched #(.DW(8), .BURST(1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data), .en(en),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .sel(sl[1]), .busy(bz[1])
`ifdef DEMUX_SCHED_STATS_EN
    , .stat_cnt(st[1])
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: a held word per instance, the channel currently being served and how many words it has had
  int         burst [2] = '{4, 1};
  logic       m_full [2];
  logic [7:0] m_data [2];
  int         m_sel [2];
  int         m_cur [2];
  int         m_done [2];
  int         m_stat [2][4];
  always @(posedge clk or posedge rst) begin : model
    int cur, done, j;
    bit x, rdy;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_full[k] <= 1'b0;
        m_data[k] <= 8'h00;
        m_sel[k]  <= 0;
        m_cur[k]  <= 0;
        m_done[k] <= 0;
        for (int c = 0; c < 4; c++) m_stat[k][c] <= 0;
      end else begin
        cur  = m_cur[k];
        done = m_done[k];
        x    = m_full[k] && out_ready[m_sel[k]];
        if (x) begin
          m_stat[k][m_sel[k]] <= (m_stat[k][m_sel[k]] + 1) % 16;
          done = (m_sel[k] == cur) ? done + 1 : 1;
          cur  = m_sel[k];
          if (done == burst[k]) begin
            cur  = (cur + 1) % 4;
            done = 0;
          end
        end
        rdy = en != 4'h0 && (!m_full[k] || x);
        if (rdy && in_valid) begin
          j = 0;
          while (!en[(cur + j) % 4]) j++;
          if (j > 0) begin
            cur  = (cur + j) % 4;
            done = 0;
          end
          m_sel[k]  <= cur;
          m_data[k] <= in_data;
          m_full[k] <= 1'b1;
        end else if (x) m_full[k] <= 1'b0;
        m_cur[k]  <= cur;
        m_done[k] <= done;
      end
    end
  end

  logic [7:0] lg [4][$];
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d out_valid", k), 32'(ov[k]), m_full[k] ? 32'(4'b0001 << m_sel[k]) : 32'h0);
      chk($sformatf("u%0d busy", k), 32'(bz[k]), 32'(m_full[k]));
      chk($sformatf("u%0d out_data", k), 32'(od[k]), 32'(m_data[k]));
      if (m_full[k]) chk($sformatf("u%0d sel", k), 32'(sl[k]), 32'(m_sel[k]));
      chk($sformatf("u%0d in_ready", k), 32'(ir[k]),
          32'(en != 4'h0 && (!m_full[k] || out_ready[m_sel[k]])));
`ifdef DEMUX_SCHED_STATS_EN
      for (int c = 0; c < 4; c++)
        chk($sformatf("u%0d stat_cnt[%0d]", k, c), 32'(st[k][c*4 +: 4]), 32'(m_stat[k][c]));
`endif
    end
    if (!rst) for (int c = 0; c < 4; c++) if (ov[0][c] && out_ready[c]) lg[c].push_back(od[0]);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    in_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  int exp2 [4] = '{0, 2, 0, 2};
  initial begin
    tick;
    chk("reset out_valid", 32'(ov[0]), 32'h0);
    chk("reset busy", 32'(bz[0]), 32'h0);
    chk("reset out_data", 32'(od[0]), 32'h0);
    chk("reset sel", 32'(sl[0]), 32'h0);
    rst = 1'b0;
    // 16-word stream, all ready: bursts of four per channel on u4, one per channel on u1
    for (int w = 0; w < 16; w++) begin
      in_valid = 1'b1;
      in_data  = 8'(w);
      #1;
      chk("stream in_ready", 32'(ir[0]), 32'h1);
      tick;
      chk("stream out_valid", 32'(ov[0]), 32'(4'b0001 << (w / 4)));
      chk("stream out_data", 32'(od[0]), 32'(w));
      chk("stream burst1 sel", 32'(sl[1]), 32'(w % 4));
    end
    in_valid = 1'b0;
    tick;
    tick;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("stream ch%0d count", c), 32'(lg[c].size()), 32'd4);
      for (int j = 0; j < 4 && j < lg[c].size(); j++)
        chk($sformatf("stream ch%0d word%0d", c, j), 32'(lg[c][j]), 32'(c * 4 + j));
    end
    // en=0101 with BURST=1 alternates 0,2
    do_reset;
    en = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h20 + i);
      tick;
      chk("alt sel", 32'(sl[1]), 32'(exp2[i]));
      chk("alt odd channels idle", 32'(ov[1] & 4'b1010), 32'h0);
    end
    in_valid = 1'b0;
    tick;
    tick;
    // backpressure on channel 0 holding 0xA5
    do_reset;
    en = 4'hF;
    out_ready = 4'b1110;
    in_valid = 1'b1;
    in_data = 8'hA5;
    tick;
    in_data = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      chk("stall out_valid", 32'(ov[0]), 32'h1);
      chk("stall out_data", 32'(od[0]), 32'hA5);
      chk("stall in_ready", 32'(ir[0]), 32'h0);
      tick;
    end
    out_ready = 4'hF;
    #1;
    chk("release in_ready", 32'(ir[0]), 32'h1);
    tick;
    chk("release out_data", 32'(od[0]), 32'h5A);
    chk("release out_valid", 32'(ov[0]), 32'h1);
    in_valid = 1'b0;
    tick;
    // en[1] dropped while a word is held for channel 1
    do_reset;
    for (int w = 0; w < 5; w++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h40 + w);
      tick;
    end
    chk("hold sel", 32'(sl[0]), 32'h1);
    in_valid = 1'b0;
    en = 4'b1101;
    out_ready = 4'b1101;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("disabled hold out_valid", 32'(ov[0]), 32'b0010);
      chk("disabled hold out_data", 32'(od[0]), 32'h44);
    end
    out_ready = 4'hF;
    in_valid = 1'b1;
    in_data = 8'h77;
    tick;
    chk("skip sel", 32'(sl[0]), 32'h2);
    chk("skip out_data", 32'(od[0]), 32'h77);
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'h78 + i);
      tick;
      chk("skip burst sel", 32'(sl[0]), 32'h2);
    end
    in_data = 8'h7B;
    tick;
    chk("skip rotate sel", 32'(sl[0]), 32'h3);
    in_valid = 1'b0;
    tick;
    // reset mid-burst with a word held
    do_reset;
    en = 4'hF;
    for (int w = 0; w < 3; w++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h50 + w);
      tick;
    end
    in_valid = 1'b0;
    out_ready = 4'b1110;
    chk("pre-reset busy", 32'(bz[0]), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(ov[0]), 32'h0);
    chk("async rst busy", 32'(bz[0]), 32'h0);
`ifdef DEMUX_SCHED_STATS_EN
    chk("async rst stat_cnt", 32'(st[0]), 32'h0);
`endif
    tick;
    rst = 1'b0;
    en = 4'h0;
    out_ready = 4'hF;
    #1;
    chk("en=0 in_ready", 32'(ir[0]), 32'h0);
    in_valid = 1'b1;
    in_data = 8'h99;
    tick;
    chk("en=0 no accept", 32'(ov[0]), 32'h0);
    en = 4'hF;
    #1;
    chk("re-enable in_ready", 32'(ir[0]), 32'h1);
    tick;
    chk("post-reset sel", 32'(sl[0]), 32'h0);
    chk("post-reset out_valid", 32'(ov[0]), 32'h1);
    chk("post-reset out_data", 32'(od[0]), 32'h99);
    in_valid = 1'b0;
    tick;
    // 17 words to channel 0 only
    do_reset;
    en = 4'b0001;
    for (int w = 0; w < 17; w++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h60 + w);
      tick;
      chk("ch0-only sel", 32'(sl[0]), 32'h0);
    end
    in_valid = 1'b0;
    tick;
    tick;
`ifdef DEMUX_SCHED_STATS_EN
    chk("stat wrap u4", 32'(st[0][3:0]), 32'h1);
    chk("stat wrap u1", 32'(st[1][3:0]), 32'h1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux_rr_sched.md
# demux_rr_sched

Round-robin scheduler that sequences the 1-to-4 demultiplexer path: it accepts a single valid/ready input stream and steers each word to one of four output channels.
- It rotates between enabled channels in bursts of BURST words.
- It holds one word in an internal register until the selected channel accepts it.
- It sits between a single producer and four consumers, and drives the demux select from a registered channel pointer.

## Interface
- DW, 8, data width
- BURST, 4, words sent to one channel before rotating (1..255)
- CNT_W, 16, width of each statistics counter (only with DEMUX_SCHED_STATS_EN)

Clock and reset are fixed: one clock; reset is asynchronous and active-high.

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  producer has a word
- in_ready  out  1  scheduler accepts the word this cycle
- in_data  in  DW  input word
- en  in  4  per-channel enable; bit i enables channel i
- out_valid  out  4  one-hot or zero; bit i means a word is offered to channel i
- out_ready  in  4  per-channel consumer ready
- out_data  out  DW  held word, shared by all channels
- sel  out  2  channel of the held word (the demux select)
- busy  out  1  a word is held
- stat_cnt  out  4*CNT_W  words delivered per channel; channel i is at [i*CNT_W +: CNT_W]; present only with DEMUX_SCHED_STATS_EN

## Operation
- State: FSM {EMPTY, FULL}, buffer buf[DW], sel[1:0], round-robin pointer ptr[1:0], burst counter bcnt[7:0].
- Reset values: state=EMPTY, ptr=0, bcnt=0, sel=0, buf=0, stat_cnt=0. Outputs at reset: out_valid=0, busy=0, out_data=0, sel=0.
- Delivery: `xfer = FULL && out_ready[sel]`.
- Pointer update on xfer: if bcnt==BURST-1, ptr=sel+1 mod 4 and bcnt=0; otherwise ptr=sel and bcnt=bcnt+1. ptr_n/bcnt_n are the values after this update, or the current values if there is no xfer.
- Target of the next accepted word:
  - ptr_n, if en[ptr_n] is set;
  - otherwise the first enabled channel searching cyclically ptr_n+1, ptr_n+2, ptr_n+3; in this case bcnt restarts at 0.
- in_ready = (en != 0) && (EMPTY || xfer). This is a combinational path out_ready -> in_ready.
- Accept = in_valid && in_ready: buf<=in_data, sel<=target, state<=FULL.
- xfer without accept: state<=EMPTY.
- FULL: out_valid = one-hot(sel), out_data=buf, busy=1. EMPTY: out_valid=0, busy=0, out_data holds its last value.
- Clearing en[sel] while FULL does not drop or redirect the held word; it is still delivered to sel.
- en==0: no new accepts; a held word still drains.
- Ready on a non-selected channel is ignored.
- rst asserted mid-transfer discards the held word immediately; there is no partial delivery.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 word/cycle when the selected consumer holds out_ready high.
- out_valid, sel and out_data come from registers only. in_ready is combinational.
- A simultaneous xfer and accept in one cycle keeps state=FULL; the new sel takes effect the next cycle.
- A rotation occurs exactly after the BURST-th delivered word to a channel. With BURST=1 the scheduler rotates every word.

## Configuration
- DEMUX_SCHED_STATS_EN defined: the stat_cnt port and four CNT_W counters exist.
  - Counter i increments on every xfer with sel==i.
  - It wraps from 2^CNT_W-1 to 0.
  - rst clears it.
- DEMUX_SCHED_STATS_EN not defined: no stat_cnt port and no counters; all other behaviour is identical.

## Structure
- Shared package demux_sched_pkg contains:
  - state enum {EMPTY, FULL};
  - NCH=4 constant;
  - a function next_enabled(ptr, en) returning the target channel and a skipped flag.
- One sub-module, rr_pick4: combinational cyclic first-enabled search (inputs ptr, en; outputs target, skipped). It is instantiated once; everything else lives in demux_rr_sched.

## Test plan
- Reset, en=4'hF, BURST=4, all out_ready=1, 16 words 0x00..0x0F streamed back-to-back -> channel 0 gets 0x00–0x03, channel 1 gets 0x04–0x07, channel 2 gets 0x08–0x0B, channel 3 gets 0x0C–0x0F; in_ready stays 1; each word appears 1 cycle after accept.
- en=4'b0101, BURST=1, 4 words -> sel sequence 0,2,0,2; channels 1 and 3 never see out_valid.
- Channel 0 out_ready=0 for 5 cycles with a word 0xA5 held -> out_valid=4'b0001 and out_data=0xA5 stable, in_ready=0; after out_ready[0]=1, xfer occurs that cycle and the next word is accepted the same cycle.
- en[1] cleared while a word is held for channel 1 -> the word is still delivered on channel 1; the next word goes to channel 2 with bcnt=0.
- rst pulsed while FULL, mid-burst at bcnt=2 -> out_valid=0 and busy=0 immediately; after release the first word goes to channel 0; stat_cnt=0 (stats build); en=0 -> in_ready=0.
- Stats build with CNT_W=4: 17 words to channel 0 -> stat_cnt[3:0] reads 1 (wrapped).
